// File: rtl/minicpu_pkg.sv
// Shared MiniCPU definitions: datapath widths, fetch FSM states, opcode fields.
// Pure declarations, no logic and no latency.
// Imported by the fetch unit and its output register.
package minicpu_pkg;

  // Instruction ROM address width (ROM depth is 2**ADDR_W) and instruction width
  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;
  localparam int COUNT_W = 8;

  // Fetch unit control states
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_e;

  // Opcode field lives in the upper nibble of every instruction
  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LDA   = 4'b0001;
  localparam logic [3:0] OP_LDB   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_STORE = 4'b1000;

  // Extract the opcode field from a raw instruction
  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: 4];
  endfunction

endpackage

// File: rtl/instr_out_reg.sv
// Valid/ready output register holding one fetched instruction and its address.
// Latency: a load is visible one cycle later; flush clears valid on the next edge.
// Backpressure: contents hold while valid && !ready; the owner must only load when free.
module instr_out_reg
  import minicpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               ready_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               valid_q;

  // Flush beats load; otherwise a load refills, and an accepted entry with no refill empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, addresses the ROM, hands instructions to decode.
// Latency: start -> ROM address next cycle -> instr_valid the cycle after; then 1/cycle.
// Backpressure: instr_valid && !instr_ready freezes PC and output; redirect flushes.
module instr_fetch
  import minicpu_pkg::*;
#(
  parameter int unsigned PC_START = 0,
  parameter int unsigned PC_LAST  = 11,
  parameter bit          WRAP_EN  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               busy,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam logic [ADDR_W-1:0] PC_START_A = ADDR_W'(PC_START);
  localparam logic [ADDR_W-1:0] PC_LAST_A  = ADDR_W'(PC_LAST);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [COUNT_W-1:0] fetch_count_q;
  logic [COUNT_W-1:0] fetch_count_d;
  logic               busy_q;
  logic               halted_q;

  logic xfer;
  logic redirect_en;
  logic capture;

  // A transfer happens whenever the decoder takes a valid instruction, in any state
  assign xfer = instr_valid && instr_ready;

  // Redirect only acts once fetching has been started at least once
  assign redirect_en = redirect_valid && (state_q != FS_IDLE);

  // Capture needs RUN, a free (or draining) output register and no redirect this cycle
  assign capture = (state_q == FS_RUN) && !redirect_valid && (!instr_valid || instr_ready);

  // Saturating transfer counter increment
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (xfer && (fetch_count_q != {COUNT_W{1'b1}})) begin
      fetch_count_d = fetch_count_q + 1'b1;
    end
  end

  // Fetch control FSM: PC sequencing, transfer counting and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FS_IDLE;
      pc_q          <= PC_START_A;
      fetch_count_q <= '0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      fetch_count_q <= fetch_count_d;
      case (state_q)
        FS_IDLE: begin
          if (start) begin
            pc_q          <= PC_START_A;
            fetch_count_q <= '0;
            state_q       <= FS_RUN;
            busy_q        <= 1'b1;
            halted_q      <= 1'b0;
          end
        end
        FS_RUN: begin
          if (redirect_en) begin
            pc_q <= redirect_pc;
          end else if (capture) begin
            if (pc_q == PC_LAST_A) begin
              if (WRAP_EN) begin
                pc_q <= PC_START_A;
              end else begin
                // PC parks on the last address; only start or redirect moves it again
                state_q  <= FS_DONE;
                busy_q   <= 1'b0;
                halted_q <= 1'b1;
              end
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end
        FS_DONE: begin
          // Redirect outranks a simultaneous start; start then restarts the count
          if (redirect_en) begin
            pc_q     <= redirect_pc;
            state_q  <= FS_RUN;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
          end else if (start) begin
            pc_q          <= PC_START_A;
            fetch_count_q <= '0;
            state_q       <= FS_RUN;
            busy_q        <= 1'b1;
            halted_q      <= 1'b0;
          end
        end
        default: begin
          state_q  <= FS_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  instr_out_reg u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (capture),
    .flush_i (redirect_en),
    .ready_i (instr_ready),
    .instr_i (imem_instr),
    .pc_i    (pc_q),
    .instr_o (instr_out),
    .pc_o    (instr_pc),
    .valid_o (instr_valid)
  );

  assign imem_addr   = pc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch unit for the MiniCPU core. It owns the program counter, drives the combinational instruction ROM address, and captures the returned 8-bit instruction into an output register. It presents that instruction to the decoder through a valid/ready handshake and accepts PC redirects from execute. The unit runs from a start pulse until the last program address, then halts or wraps.

Parameters:
ADDR_W, 4, instruction address width (ROM depth 2^ADDR_W)
INSTR_W, 8, instruction width
PC_START, 0, PC loaded on reset and on start
PC_LAST, 11, last valid program address
WRAP_EN, 0, 1: after PC_LAST continue at PC_START; 0: halt

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse, begin fetching from PC_START
imem_addr  output  ADDR_W  address to instruction ROM (registered)
imem_instr  input  INSTR_W  ROM data, combinational from imem_addr
instr_out  output  INSTR_W  captured instruction to decoder
instr_pc  output  ADDR_W  address instr_out was fetched from
instr_valid  output  1  instr_out/instr_pc valid
instr_ready  input  1  decoder accepts instr_out this cycle
redirect_valid  input  1  load PC with redirect_pc, flush output
redirect_pc  input  ADDR_W  redirect target
busy  output  1  state == RUN
halted  output  1  state == DONE
fetch_count  output  8  accepted handshakes since start, saturating at 255

Behaviour:
- Reset (async, immediate, mid-operation included): state=IDLE, pc=PC_START, imem_addr=PC_START, instr_out=0, instr_pc=0, instr_valid=0, busy=0, halted=0, fetch_count=0.
- imem_addr is always equal to the registered pc.
- States:
  - IDLE: on start, pc<=PC_START, fetch_count<=0, go to RUN.
  - RUN: fetches while the output register is free.
  - DONE: on start, behaves as it does in IDLE; start is ignored in RUN.
- Capture in RUN: when (!instr_valid || instr_ready) and !redirect_valid:
  - instr_out<=imem_instr, instr_pc<=pc, instr_valid<=1.
  - If pc==PC_LAST: WRAP_EN=1 gives pc<=PC_START; WRAP_EN=0 gives state<=DONE and pc holds.
  - Otherwise pc<=pc+1. Arithmetic is modulo 2^ADDR_W.
- Latency: start sampled at edge N means imem_addr=PC_START during cycle N+1 and instr_valid=1 with ROM[PC_START] during cycle N+2. With instr_ready held high, throughput is one instruction per cycle.
- Stall: while instr_valid && !instr_ready, instr_out, instr_pc, pc and imem_addr hold stable. There is no capture and no loss.
- Handshake: transfer occurs on an edge where instr_valid && instr_ready. fetch_count increments per transfer and saturates at 255.
- No capture occurs in IDLE or DONE.
- In DONE, a pending instr_valid remains until accepted, then drops. No new fetch occurs.
- Redirect (RUN or DONE, highest priority):
  - pc<=redirect_pc, instr_valid<=0 (flush), state<=RUN.
  - The capture that cycle is suppressed.
  - A handshake in the same cycle still counts as a transfer. The instruction was delivered, then the register is flushed.
  - redirect_pc > PC_LAST is legal; fetch proceeds and wraps or halts only on reaching PC_LAST.
- Redirect in IDLE is ignored.
- Simultaneous start and redirect in DONE: redirect wins.

Decomposition:
- Shared package minicpu_pkg:
  - ADDR_W and INSTR_W constants.
  - Fetch state enum (IDLE, RUN, DONE).
  - Opcode field constants (upper nibble): OP_NOP=0000, OP_LDA=0001, OP_LDB=0010, OP_ADD=0100, OP_STORE=1000.
- One natural sub-module, instr_out_reg: valid/ready output register with flush, holding instr_out, instr_pc and instr_valid.

Test Plan:
- Reset, then start pulse with instr_ready=1 and ROM program 0:0x13, 1:0x25, 2:0x40 -> instr_valid rises 2 cycles after start; instr_out/instr_pc sequence is 0x13/0, 0x25/1, 0x40/2, one per cycle.
- Run with instr_ready=0 for 3 cycles while instr_valid=1 at pc 1 -> instr_out holds 0x25, imem_addr holds 2; release -> 0x40/2 appears next, nothing skipped or duplicated.
- WRAP_EN=0, PC_LAST=11, ready=1 -> instr_pc 11 delivered, halted=1, busy=0, fetch_count=12; no further valid; start restarts at pc 0.
- WRAP_EN=1 -> after instr_pc 11 the next instr_pc is 0; halted stays 0.
- redirect_valid with redirect_pc=8 while instr_pc=2 is valid and ready=1 -> transfer of pc 2 counted, next cycle instr_valid=0, following cycle instr_out=ROM[8]=0x14, instr_pc=8.
- Assert rst asynchronously mid-stall (between clock edges) -> all outputs return to reset values immediately; after release the block stays IDLE until start.
